// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin sharing of one sprite ROM between N_REQ drawers, with tagged read returns
// Optional stall counter port and logic are enabled by defining SPRITE_ARB_STALL_CNT_EN.
module sprite_rom_arbiter #(
   parameter int N_REQ   = 4,
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 2,
   parameter int ROM_LAT = 1
) (
   input  logic                       vga_clk,
   input  logic                       reset,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ*ADDR_W-1:0]    addr,
   output logic [N_REQ-1:0]           gnt,
   output logic [ADDR_W-1:0]          rom_addr,
   input  logic [DATA_W-1:0]          rom_q,
   output logic [DATA_W-1:0]          rdata,
   output logic                       rvalid,
   output logic [$clog2(N_REQ)-1:0]   rid
`ifdef SPRITE_ARB_STALL_CNT_EN
   ,
   output logic [15:0]                stall_cnt
`endif
);
   localparam int ID_W = $clog2(N_REQ);
   logic [ID_W-1:0]               ptr, win;
   logic                          hit, grant;
   logic [ROM_LAT-1:0]            vld;
   logic [ROM_LAT-1:0][ID_W-1:0]  tag;
   // search from ptr upward, wrapping, for the first active request
   always_comb begin
      hit = 1'b0;
      win = '0;
      for (int k = 0; k < N_REQ; k++)
         if (!hit && req[(int'(ptr) + k) % N_REQ]) begin
            hit = 1'b1;
            win = ID_W'((int'(ptr) + k) % N_REQ);
         end
   end
   // requests are ignored while reset is held
   always_comb begin
      grant = hit && !reset;
      gnt   = grant ? (N_REQ'(1) << win) : '0;
   end
   // ROM address register, round-robin pointer and tag pipeline
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         ptr      <= '0;
         rom_addr <= '0;
         vld      <= '0;
         tag      <= '0;
      end else begin
         if (grant) begin
            rom_addr <= addr[win*ADDR_W +: ADDR_W];
            ptr      <= (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
         end
         vld[0] <= grant;
         tag[0] <= win;
         for (int i = 1; i < ROM_LAT; i++) begin
            vld[i] <= vld[i-1];
            tag[i] <= tag[i-1];
         end
      end
   end
   // capture the ROM word together with the tag leaving the last stage
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         rvalid <= 1'b0;
         rid    <= '0;
         rdata  <= '0;
      end else begin
         rvalid <= vld[ROM_LAT-1];
         rid    <= tag[ROM_LAT-1];
         if (vld[ROM_LAT-1]) rdata <= rom_q;
      end
   end
`ifdef SPRITE_ARB_STALL_CNT_EN
   // count cycles in which some request waited, saturating at all ones
   always_ff @(posedge vga_clk) begin
      if (reset) stall_cnt <= '0;
      else if (|(req & ~gnt) && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
   end
`endif
endmodule
